// File: rtl/sr_flag_arbiter_if.sv
// rtl/sr_flag_arbiter_if.sv - requester/arbiter bus for the SR flag bank
// Purpose: bundles the per-requester command lines and the arbiter status lines.
// Ports (signals):
//   req[NREQ], op_set[NREQ], idx[NREQ*IDXW]   requester -> arbiter
//   ack[NREQ], err, busy, grant_id[3]         arbiter -> requester
//   flags[NFLAG], flags_bar[NFLAG]            arbiter -> requester
// Modports: master = requester side, slave = arbiter side.
interface sr_flag_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      op_set;
    logic [NREQ*IDXW-1:0] idx;
    logic [NREQ-1:0]      ack;
    logic                 err;
    logic                 busy;
    logic [2:0]           grant_id;
    logic [NFLAG-1:0]     flags;
    logic [NFLAG-1:0]     flags_bar;

    modport master (
        output req, op_set, idx,
        input  ack, err, busy, grant_id, flags, flags_bar
    );

    modport slave (
        input  req, op_set, idx,
        output ack, err, busy, grant_id, flags, flags_bar
    );
endinterface

// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - round-robin arbiter driving a bank of SR flags
// Purpose: arbitrates set/clear commands from NREQ requesters onto NFLAG
//   SR flag bits, one transaction at a time (IDLE -> APPLY -> ACK).
// Ports:
//   clk    rising-edge clock
//   n_rst  asynchronous active-low reset
//   bus    sr_flag_arbiter_if.slave: req/op_set/idx in; ack/err/busy/
//          grant_id/flags/flags_bar out
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
) (
    input  logic                clk,
    input  logic                n_rst,
    sr_flag_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        id_q, id_d;
    logic              op_q, op_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [2:0]        grant_id_q, grant_id_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [NFLAG-1:0]  flags_q, flags_d;

    logic              found;
    logic [2:0]        win;
    logic [3:0]        sum;
    logic [2:0]        cand;
    logic              in_range;
    logic [NFLAG-1:0]  s_vec;
    logic [NFLAG-1:0]  r_vec;

    // Round-robin search starting at ptr; wrap is done by subtraction since
    // ptr + offset never exceeds 2*NREQ-2.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        sum   = 4'd0;
        cand  = 3'd0;
        for (int j = 0; j < NREQ; j++) begin
            sum  = {1'b0, ptr_q} + 4'(j);
            cand = 3'((sum >= 4'(NREQ)) ? (sum - 4'(NREQ)) : sum);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign in_range = (32'(idx_q) < NFLAG);

    // s and r for a flag are gated by op_q and ~op_q respectively, so they
    // can never both be high; outside APPLY every flag holds.
    always_comb begin
        s_vec = '0;
        r_vec = '0;
        for (int i = 0; i < NFLAG; i++) begin
            if ((state_q == ST_APPLY) && in_range && (idx_q == IDXW'(i))) begin
                s_vec[i] = op_q;
                r_vec[i] = ~op_q;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        op_d       = op_q;
        idx_d      = idx_q;
        grant_id_d = grant_id_q;
        ack_d      = '0;
        err_d      = 1'b0;
        busy_d     = busy_q;
        flags_d    = (flags_q | s_vec) & ~r_vec;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (found) begin
                    id_d       = win;
                    op_d       = bus.op_set[win];
                    idx_d      = bus.idx[win*IDXW +: IDXW];
                    grant_id_d = win;
                    busy_d     = 1'b1;
                    state_d    = ST_APPLY;
                end
            end
            ST_APPLY: begin
                ack_d   = NREQ'(1) << id_q;
                err_d   = ~in_range;
                busy_d  = 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                ptr_d   = (id_q == 3'(NREQ - 1)) ? 3'd0 : (id_q + 3'd1);
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 3'd0;
            id_q       <= 3'd0;
            op_q       <= 1'b0;
            idx_q      <= '0;
            grant_id_q <= 3'd0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            grant_id_q <= grant_id_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            flags_q    <= flags_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.flags     = flags_q;
    assign bus.flags_bar = ~flags_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb/tb_sr_flag_arbiter.sv - directed self-checking bench for sr_flag_arbiter
module tb_sr_flag_arbiter;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sr_flag_arbiter_if #(.NREQ(4), .NFLAG(8), .IDXW(3)) bus8 ();
    sr_flag_arbiter_if #(.NREQ(4), .NFLAG(6), .IDXW(3)) bus6 ();

    sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDXW(3)) dut8 (
        .clk(clk), .n_rst(n_rst), .bus(bus8.slave)
    );
    sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .IDXW(3)) dut6 (
        .clk(clk), .n_rst(n_rst), .bus(bus6.slave)
    );

    task automatic set_req8(input int k, input logic op, input logic [2:0] ix);
        bus8.req[k]          = 1'b1;
        bus8.op_set[k]       = op;
        bus8.idx[k*3 +: 3]   = ix;
    endtask

    task automatic set_req6(input int k, input logic op, input logic [2:0] ix);
        bus6.req[k]          = 1'b1;
        bus6.op_set[k]       = op;
        bus6.idx[k*3 +: 3]   = ix;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus8.flags !== 8'h00) begin errors++; $display("FAIL reset_flags got %h exp 00", bus8.flags); end
        checks++; if (bus8.flags_bar !== 8'hFF) begin errors++; $display("FAIL reset_flags_bar got %h exp ff", bus8.flags_bar); end
        checks++; if (bus8.ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b exp 0000", bus8.ack); end
        checks++; if (bus8.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus8.err); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus8.busy); end
        checks++; if (bus8.grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant_id got %0d exp 0", bus8.grant_id); end
        checks++; if (bus6.flags_bar !== 6'h3F) begin errors++; $display("FAIL reset_flags_bar6 got %h exp 3f", bus6.flags_bar); end
        n_rst = 1'b1;
    endtask

    task automatic test_single_set();
        set_req8(0, 1'b1, 3'd3);
        @(negedge clk);
        checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL single_busy_apply got %b exp 1", bus8.busy); end
        checks++; if (bus8.ack !== 4'b0000) begin errors++; $display("FAIL single_ack_apply got %b exp 0000", bus8.ack); end
        checks++; if (bus8.flags !== 8'h00) begin errors++; $display("FAIL single_flags_apply got %h exp 00", bus8.flags); end
        @(negedge clk);
        checks++; if (bus8.ack !== 4'b0001) begin errors++; $display("FAIL single_ack got %b exp 0001", bus8.ack); end
        checks++; if (bus8.flags !== 8'h08) begin errors++; $display("FAIL single_flags got %h exp 08", bus8.flags); end
        checks++; if (bus8.err !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", bus8.err); end
        checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL single_busy_ack got %b exp 1", bus8.busy); end
        bus8.req[0] = 1'b0;
        @(negedge clk);
        checks++; if (bus8.ack !== 4'b0000) begin errors++; $display("FAIL single_ack_idle got %b exp 0000", bus8.ack); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b exp 0", bus8.busy); end
    endtask

    task automatic test_clear();
        set_req8(2, 1'b0, 3'd3);
        repeat (2) @(negedge clk);
        checks++; if (bus8.ack !== 4'b0100) begin errors++; $display("FAIL clear_ack got %b exp 0100", bus8.ack); end
        checks++; if (bus8.grant_id !== 3'd2) begin errors++; $display("FAIL clear_grant_id got %0d exp 2", bus8.grant_id); end
        checks++; if (bus8.flags !== 8'h00) begin errors++; $display("FAIL clear_flags got %h exp 00", bus8.flags); end
        checks++; if (bus8.flags_bar !== 8'hFF) begin errors++; $display("FAIL clear_flags_bar got %h exp ff", bus8.flags_bar); end
        bus8.req[2] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ack;
        int g;
        do_reset();
        for (int k = 0; k < 4; k++) set_req8(k, 1'b1, 3'(k));
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            g = (cyc / 3) % 4;
            exp_ack = (cyc % 3 == 2) ? (4'b0001 << g) : 4'b0000;
            checks++; if (bus8.ack !== exp_ack) begin errors++; $display("FAIL rr_ack cyc %0d got %b exp %b", cyc, bus8.ack, exp_ack); end
            if (cyc % 3 == 2) begin
                checks++; if (bus8.grant_id !== 3'(g)) begin errors++; $display("FAIL rr_grant_id cyc %0d got %0d exp %0d", cyc, bus8.grant_id, g); end
            end
        end
        bus8.req = 4'b0000;
        checks++; if (bus8.flags !== 8'h0F) begin errors++; $display("FAIL rr_flags got %h exp 0f", bus8.flags); end
        @(negedge clk);
    endtask

    task automatic test_conflict();
        do_reset();
        set_req8(1, 1'b1, 3'd5);
        set_req8(3, 1'b0, 3'd5);
        repeat (2) @(negedge clk);
        checks++; if (bus8.ack !== 4'b0010) begin errors++; $display("FAIL conflict_ack1 got %b exp 0010", bus8.ack); end
        checks++; if (bus8.flags !== 8'h20) begin errors++; $display("FAIL conflict_flags1 got %h exp 20", bus8.flags); end
        bus8.req[1] = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus8.ack !== 4'b1000) begin errors++; $display("FAIL conflict_ack3 got %b exp 1000", bus8.ack); end
        checks++; if (bus8.grant_id !== 3'd3) begin errors++; $display("FAIL conflict_grant_id got %0d exp 3", bus8.grant_id); end
        checks++; if (bus8.flags !== 8'h00) begin errors++; $display("FAIL conflict_flags3 got %h exp 00", bus8.flags); end
        bus8.req[3] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        set_req6(0, 1'b1, 3'd2);
        repeat (2) @(negedge clk);
        checks++; if (bus6.flags !== 6'h04) begin errors++; $display("FAIL oor_pre_flags got %h exp 04", bus6.flags); end
        bus6.req[0] = 1'b0;
        @(negedge clk);
        set_req6(0, 1'b1, 3'd7);
        repeat (2) @(negedge clk);
        checks++; if (bus6.ack !== 4'b0001) begin errors++; $display("FAIL oor7_ack got %b exp 0001", bus6.ack); end
        checks++; if (bus6.err !== 1'b1) begin errors++; $display("FAIL oor7_err got %b exp 1", bus6.err); end
        checks++; if (bus6.flags !== 6'h04) begin errors++; $display("FAIL oor7_flags got %h exp 04", bus6.flags); end
        checks++; if (bus6.flags_bar !== 6'h3B) begin errors++; $display("FAIL oor7_flags_bar got %h exp 3b", bus6.flags_bar); end
        bus6.req[0] = 1'b0;
        @(negedge clk);
        checks++; if (bus6.err !== 1'b0) begin errors++; $display("FAIL oor7_err_drop got %b exp 0", bus6.err); end
        set_req6(1, 1'b0, 3'd6);
        repeat (2) @(negedge clk);
        checks++; if (bus6.ack !== 4'b0010) begin errors++; $display("FAIL oor6_ack got %b exp 0010", bus6.ack); end
        checks++; if (bus6.err !== 1'b1) begin errors++; $display("FAIL oor6_err got %b exp 1", bus6.err); end
        checks++; if (bus6.flags !== 6'h04) begin errors++; $display("FAIL oor6_flags got %h exp 04", bus6.flags); end
        bus6.req[1] = 1'b0;
        @(negedge clk);
        set_req6(2, 1'b1, 3'd5);
        repeat (2) @(negedge clk);
        checks++; if (bus6.err !== 1'b0) begin errors++; $display("FAIL last_idx_err got %b exp 0", bus6.err); end
        checks++; if (bus6.flags !== 6'h24) begin errors++; $display("FAIL last_idx_flags got %h exp 24", bus6.flags); end
        bus6.req[2] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        set_req8(1, 1'b1, 3'd7);
        repeat (2) @(negedge clk);
        checks++; if (bus8.flags !== 8'h80) begin errors++; $display("FAIL mid_pre_flags got %h exp 80", bus8.flags); end
        bus8.req[1] = 1'b0;
        @(negedge clk);
        set_req8(2, 1'b1, 3'd1);
        @(negedge clk);
        checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_apply got %b exp 1", bus8.busy); end
        n_rst = 1'b0;
        #1;
        checks++; if (bus8.flags !== 8'h00) begin errors++; $display("FAIL mid_flags got %h exp 00", bus8.flags); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", bus8.busy); end
        checks++; if (bus8.grant_id !== 3'd0) begin errors++; $display("FAIL mid_grant_id got %0d exp 0", bus8.grant_id); end
        bus8.req[2] = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        checks++; if (bus8.ack !== 4'b0000) begin errors++; $display("FAIL mid_ack got %b exp 0000", bus8.ack); end
        checks++; if (bus8.flags !== 8'h00) begin errors++; $display("FAIL mid_flags_after got %h exp 00", bus8.flags); end
        set_req8(0, 1'b1, 3'd4);
        set_req8(3, 1'b1, 3'd6);
        repeat (2) @(negedge clk);
        checks++; if (bus8.ack !== 4'b0001) begin errors++; $display("FAIL mid_ptr_ack got %b exp 0001", bus8.ack); end
        checks++; if (bus8.flags !== 8'h10) begin errors++; $display("FAIL mid_ptr_flags got %h exp 10", bus8.flags); end
        bus8.req[0] = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus8.ack !== 4'b1000) begin errors++; $display("FAIL mid_next_ack got %b exp 1000", bus8.ack); end
        checks++; if (bus8.flags !== 8'h50) begin errors++; $display("FAIL mid_next_flags got %h exp 50", bus8.flags); end
        bus8.req[3] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation exceeded 100000 time units");
        $fatal(1);
    end

    initial begin
        bus8.req    = '0;
        bus8.op_set = '0;
        bus8.idx    = '0;
        bus6.req    = '0;
        bus6.op_set = '0;
        bus6.idx    = '0;
        test_reset();
        test_single_set();
        test_clear();
        test_round_robin();
        test_conflict();
        test_out_of_range();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
